// File: rtl/reg_file_pkg.sv
// Shared types, limits and helpers for the multi-port register file
// with its busy scoreboard.
package reg_file_pkg;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    localparam int MAX_NUM_RD = 4;
    localparam int MAX_NUM_WR = 2;

    function automatic int addr_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: waits in WAIT on a busy register, then loads the
// bypassed data the top level presents for cur_addr.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic               ready,
    input  logic [D_WIDTH-1:0] byp_data,
    output logic [ADDR_W-1:0]  cur_addr,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_stall
);

    rd_state_e         state;
    logic [ADDR_W-1:0] cap_addr;

    // In WAIT the request inputs are ignored and the captured address is re-checked.
    assign cur_addr = (state == RD_WAIT) ? cap_addr : rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RD_IDLE;
            cap_addr <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_stall <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (rd_req) begin
                        if (ready) begin
                            rd_data  <= byp_data;
                            rd_valid <= 1'b1;
                        end else begin
                            cap_addr <= rd_addr;
                            rd_stall <= 1'b1;
                            state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (ready) begin
                        rd_data  <= byp_data;
                        rd_valid <= 1'b1;
                        rd_stall <= 1'b0;
                        state    <= RD_IDLE;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage, busy scoreboard, write logic and
// per-read-port bypass muxes feeding an array of read-port FSMs.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int D_WIDTH  = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_en,
    input  logic [ADDR_W-1:0]         alloc_addr,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]  wr_addr,
    input  logic [NUM_WR*D_WIDTH-1:0] wr_data,
    input  logic [NUM_RD-1:0]         rd_req,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*D_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]         rd_valid,
    output logic [NUM_RD-1:0]         rd_stall,
    output logic [NUM_REGS-1:0]       busy
);

    localparam bit ZR = (ZERO_REG != 0);

    if (NUM_RD < 1 || NUM_RD > MAX_NUM_RD || NUM_WR < 1 || NUM_WR > MAX_NUM_WR ||
        NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_param_err
        $error("reg_file_mp: illegal parameter combination");
    end

    logic [NUM_REGS-1:0][D_WIDTH-1:0] mem;
    logic [NUM_REGS-1:0]              busy_nxt;
    logic [NUM_WR-1:0][ADDR_W-1:0]    wa;
    logic [NUM_WR-1:0][D_WIDTH-1:0]   wd;
    logic [NUM_RD-1:0][ADDR_W-1:0]    cur_addr;
    logic [NUM_RD-1:0]                rdy;
    logic [NUM_RD-1:0][D_WIDTH-1:0]   byp;

    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            wa[i] = wr_addr[i*ADDR_W +: ADDR_W];
            wd[i] = wr_data[i*D_WIDTH +: D_WIDTH];
        end
    end

    // Later loop iterations overwrite earlier ones, so the higher write port wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && !(ZR && wa[i] == ADDR_W'(0)))
                    mem[wa[i]] <= wd[i];
            end
        end
    end

    // Alloc is applied after the write clears so it wins on the same register.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i])
                busy_nxt[wa[i]] = 1'b0;
        end
        if (alloc_en)
            busy_nxt[alloc_addr] = 1'b1;
        if (ZR)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_comb begin
        rdy = '0;
        byp = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            byp[p] = mem[cur_addr[p]];
            rdy[p] = !busy[cur_addr[p]];
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && wa[i] == cur_addr[p]) begin
                    rdy[p] = 1'b1;
                    byp[p] = wd[i];
                end
            end
            if (ZR && cur_addr[p] == ADDR_W'(0)) begin
                rdy[p] = 1'b1;
                byp[p] = '0;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_file_rd_port #(
            .D_WIDTH (D_WIDTH),
            .ADDR_W  (ADDR_W)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .rd_req   (rd_req[p]),
            .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
            .ready    (rdy[p]),
            .byp_data (byp[p]),
            .cur_addr (cur_addr[p]),
            .rd_data  (rd_data[p*D_WIDTH +: D_WIDTH]),
            .rd_valid (rd_valid[p]),
            .rd_stall (rd_stall[p])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed table-driven bench for reg_file_mp with four read and two write ports.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int RD = 4;
    localparam int WR = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               alloc_en;
    logic [AW-1:0]      alloc_addr;
    logic [WR-1:0]      wr_en;
    logic [WR*AW-1:0]   wr_addr;
    logic [WR*DW-1:0]   wr_data;
    logic [RD-1:0]      rd_req;
    logic [RD*AW-1:0]   rd_addr;
    logic [RD*DW-1:0]   rd_data;
    logic [RD-1:0]      rd_valid;
    logic [RD-1:0]      rd_stall;
    logic [NR-1:0]      busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(
        .D_WIDTH (DW), .NUM_REGS (NR), .NUM_RD (RD), .NUM_WR (WR), .ZERO_REG (1)
    ) dut (
        .clk (clk), .rst (rst), .alloc_en (alloc_en), .alloc_addr (alloc_addr),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_req (rd_req), .rd_addr (rd_addr), .rd_data (rd_data),
        .rd_valid (rd_valid), .rd_stall (rd_stall), .busy (busy)
    );

    typedef struct {
        logic        al;
        logic [4:0]  al_a;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  rq;
        logic [4:0]  ra0, ra1, ra2, ra3;
        logic [3:0]  xv;
        logic [3:0]  xs;
        logic [31:0] xbusy;
        logic [31:0] xd0, xd1, xd2, xd3;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];
    logic [31:0] exp_d[RD];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_en = 1'b0; alloc_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_req = '0; rd_addr = '0;
    endtask

    task automatic chk_data(input string tag);
        for (int p = 0; p < RD; p++)
            chk($sformatf("%s data%0d", tag, p), rd_data[p*DW +: DW], exp_d[p]);
    endtask

    initial begin
        // al al_a we wa0 wd0 wa1 wd1 rq ra0..3 xv xs xbusy xd0..3
        vt[0]  = '{0,0, 2'b01, 5,32'hDEADBEEF, 0,0, 4'b0000, 0,0,0,0, 4'b0000,4'b0000, 32'h0, 0,0,0,0};
        vt[1]  = '{0,0, 2'b00, 0,0, 0,0, 4'b0001, 5,0,0,0, 4'b0001,4'b0000, 32'h0, 32'hDEADBEEF,0,0,0};
        vt[2]  = '{0,0, 2'b01, 0,32'hFFFFFFFF, 0,0, 4'b0110, 0,5,0,0, 4'b0110,4'b0000, 32'h0, 0,32'hDEADBEEF,0,0};
        vt[3]  = '{0,0, 2'b00, 0,0, 0,0, 4'b0010, 0,0,0,0, 4'b0010,4'b0000, 32'h0, 0,0,0,0};
        vt[4]  = '{0,0, 2'b01, 3,32'h1, 0,0, 4'b0000, 0,0,0,0, 4'b0000,4'b0000, 32'h0, 0,0,0,0};
        vt[5]  = '{0,0, 2'b10, 0,0, 3,32'hA5A5, 4'b0100, 0,0,3,0, 4'b0100,4'b0000, 32'h0, 0,0,32'hA5A5,0};
        vt[6]  = '{1,7, 2'b00, 0,0, 0,0, 4'b0000, 0,0,0,0, 4'b0000,4'b0000, 32'h80, 0,0,0,0};
        vt[7]  = '{0,0, 2'b00, 0,0, 0,0, 4'b0010, 0,7,0,0, 4'b0000,4'b0010, 32'h80, 0,0,0,0};
        vt[8]  = '{0,0, 2'b00, 0,0, 0,0, 4'b0010, 0,5,0,0, 4'b0000,4'b0010, 32'h80, 0,0,0,0};
        vt[9]  = '{0,0, 2'b00, 0,0, 0,0, 4'b0000, 0,0,0,0, 4'b0000,4'b0010, 32'h80, 0,0,0,0};
        vt[10] = '{0,0, 2'b10, 0,0, 7,32'h1234, 4'b0000, 0,0,0,0, 4'b0010,4'b0000, 32'h0, 0,32'h1234,0,0};
        vt[11] = '{1,9, 2'b01, 9,32'h99, 0,0, 4'b0000, 0,0,0,0, 4'b0000,4'b0000, 32'h200, 0,0,0,0};
        vt[12] = '{1,9, 2'b00, 0,0, 0,0, 4'b1000, 0,0,0,9, 4'b0000,4'b1000, 32'h200, 0,0,0,0};
        vt[13] = '{0,0, 2'b01, 9,32'h99, 0,0, 4'b0000, 0,0,0,0, 4'b1000,4'b0000, 32'h0, 0,0,0,32'h99};
        vt[14] = '{0,0, 2'b11, 4,32'h11, 4,32'h22, 4'b0001, 4,0,0,0, 4'b0001,4'b0000, 32'h0, 32'h22,0,0,0};
        vt[15] = '{0,0, 2'b00, 0,0, 0,0, 4'b1111, 4,5,3,7, 4'b1111,4'b0000, 32'h0,
                   32'h22,32'hDEADBEEF,32'hA5A5,32'h1234};
        vt[16] = '{0,0, 2'b00, 0,0, 0,0, 4'b0011, 9,0,0,0, 4'b0011,4'b0000, 32'h0, 32'h99,0,0,0};
        vt[17] = '{1,0, 2'b00, 0,0, 0,0, 4'b0100, 0,0,0,0, 4'b0100,4'b0000, 32'h0, 0,0,0,0};

        for (int p = 0; p < RD; p++) exp_d[p] = '0;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset valid", 32'(rd_valid), 32'h0);
        chk("reset stall", 32'(rd_stall), 32'h0);
        chk("reset busy", busy, 32'h0);
        chk_data("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            logic [31:0] xd[RD];
            alloc_en = vt[i].al; alloc_addr = vt[i].al_a;
            wr_en = vt[i].we;
            wr_addr = {vt[i].wa1, vt[i].wa0};
            wr_data = {vt[i].wd1, vt[i].wd0};
            rd_req = vt[i].rq;
            rd_addr = {vt[i].ra3, vt[i].ra2, vt[i].ra1, vt[i].ra0};
            @(negedge clk);
            xd = '{vt[i].xd0, vt[i].xd1, vt[i].xd2, vt[i].xd3};
            for (int p = 0; p < RD; p++)
                if (vt[i].xv[p]) exp_d[p] = xd[p];
            chk($sformatf("row%0d valid", i), 32'(rd_valid), 32'(vt[i].xv));
            chk($sformatf("row%0d stall", i), 32'(rd_stall), 32'(vt[i].xs));
            chk($sformatf("row%0d busy", i), busy, vt[i].xbusy);
            chk_data($sformatf("row%0d", i));
        end

        // Reset while port 0 waits on r10: the pending read is dropped.
        idle_inputs();
        alloc_en = 1'b1; alloc_addr = 5'd10;
        @(negedge clk);
        idle_inputs();
        rd_req = 4'b0001; rd_addr = {5'd0, 5'd0, 5'd0, 5'd10};
        @(negedge clk);
        chk("wait stall", 32'(rd_stall), 32'h1);
        chk("wait busy", busy, 32'h400);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        for (int p = 0; p < RD; p++) exp_d[p] = '0;
        chk("rst mid-wait valid", 32'(rd_valid), 32'h0);
        chk("rst mid-wait stall", 32'(rd_stall), 32'h0);
        chk("rst mid-wait busy", busy, 32'h0);
        chk_data("rst mid-wait");
        rst = 1'b0;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h55};
        @(negedge clk);
        chk("post-rst valid", 32'(rd_valid), 32'h0);
        chk("post-rst stall", 32'(rd_stall), 32'h0);
        idle_inputs();
        rd_req = 4'b0011; rd_addr = {5'd0, 5'd0, 5'd10, 5'd5};
        @(negedge clk);
        exp_d[1] = 32'h55;
        chk("post-rst read valid", 32'(rd_valid), 32'h3);
        chk_data("post-rst read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
